// File: rtl/regfile_commit_writer_pkg.sv
// Shared definitions for the architectural register file writer.
// Holds the data/register typedefs and the writer FSM state enum.
// The global sizing macros are defined here only if the build has not already supplied them.
`ifndef NUMBER_OF_REGISTERS
`define NUMBER_OF_REGISTERS 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package regfile_commit_writer_pkg;

  typedef logic [`DATA_SIZE-1:0] memory_word_t;
  typedef logic [4:0]            register_t;

  typedef enum logic {
    StInit,
    StRun
  } regfile_state_e;

endpackage

// File: rtl/regfile_write_merge.sv
// Combinational write-port merge for the register array.
// Inputs : FSM state and clear index, stack-pointer init value, both retirement slots (accept,
//          rd, data).
// Outputs: per-register write enable and write data.
// During INIT only entry idx is written (sp_value at SP_REG, zero elsewhere). In RUN, slot 1
// wins over slot 0 on the same rd, and register 0 is never written.
`ifndef NUMBER_OF_REGISTERS
`define NUMBER_OF_REGISTERS 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module regfile_write_merge
  import regfile_commit_writer_pkg::*;
#(
  parameter int unsigned NUM_REGS = `NUMBER_OF_REGISTERS,
  parameter int unsigned SP_REG   = 2,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  regfile_state_e                state,
  input  logic [IDX_W-1:0]              idx,
  input  memory_word_t                  sp_value,
  input  logic                          accept0,
  input  register_t                     rd0,
  input  memory_word_t                  data0,
  input  logic                          accept1,
  input  register_t                     rd1,
  input  memory_word_t                  data1,
  output logic [NUM_REGS-1:0]           wr_en,
  output memory_word_t [NUM_REGS-1:0]   wr_data
);

  always_comb begin
    wr_en   = '0;
    wr_data = '0;
    if (state == StInit) begin
      wr_en[idx]   = 1'b1;
      wr_data[idx] = (idx == IDX_W'(SP_REG)) ? sp_value : '0;
    end else begin
      // Loop starts at 1: x0 is hard-wired to zero.
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (accept1 && (rd1 == register_t'(r))) begin
          wr_en[r]   = 1'b1;
          wr_data[r] = data1;
        end else if (accept0 && (rd0 == register_t'(r))) begin
          wr_en[r]   = 1'b1;
          wr_data[r] = data0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_commit_writer.sv
// Architectural register array and its sole writer.
// Inputs : clk, reset (synchronous, active low), sp_init, hold, two in-order retirement slots
//          (valid/rd/data).
// Outputs: per-slot ready, the registered array contents, init_done, retired_count.
// After reset the array is cleared one entry per cycle (SP_REG gets the sampled sp_init),
// then up to two retirements per cycle are written. No same-cycle bypass.
`ifndef NUMBER_OF_REGISTERS
`define NUMBER_OF_REGISTERS 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module regfile_commit_writer
  import regfile_commit_writer_pkg::*;
#(
  parameter int unsigned NUM_REGS = `NUMBER_OF_REGISTERS,
  parameter int unsigned SP_REG   = 2,
  parameter int unsigned COUNT_W  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  memory_word_t                  sp_init,
  input  logic                          hold,
  input  logic                          commit0_valid,
  input  register_t                     commit0_rd,
  input  memory_word_t                  commit0_data,
  output logic                          commit0_ready,
  input  logic                          commit1_valid,
  input  register_t                     commit1_rd,
  input  memory_word_t                  commit1_data,
  output logic                          commit1_ready,
  output memory_word_t [NUM_REGS-1:0]   register_file,
  output logic                          init_done,
  output logic [COUNT_W-1:0]            retired_count
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  regfile_state_e       state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  memory_word_t         sp_q;
  logic                 init_done_q, init_done_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  memory_word_t [NUM_REGS-1:0] rf_q;

  logic                        accept0, accept1;
  logic [NUM_REGS-1:0]         wr_en;
  memory_word_t [NUM_REGS-1:0] wr_data;

  // Ready depends only on state and hold so the ROB never sees a valid->ready loop.
  always_comb begin
    commit0_ready = (state_q == StRun) && !hold;
    commit1_ready = (state_q == StRun) && !hold;
  end

  assign accept0 = commit0_valid && commit0_ready;
  assign accept1 = commit1_valid && commit1_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    count_d     = count_q;
    unique case (state_q)
      StInit: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IdxW'(NUM_REGS - 1)) begin
          state_d     = StRun;
          init_done_d = 1'b1;
        end
      end
      StRun: begin
        count_d = count_q + COUNT_W'(accept0) + COUNT_W'(accept1);
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StInit;
      idx_q       <= '0;
      sp_q        <= sp_init;
      init_done_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      count_q     <= count_d;
    end
  end

  // Array is not bulk-reset; INIT clears it. Writes on a reset edge are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (wr_en[r]) begin
          rf_q[r] <= wr_data[r];
        end
      end
    end
  end

  regfile_write_merge #(
    .NUM_REGS (NUM_REGS),
    .SP_REG   (SP_REG),
    .IDX_W    (IdxW)
  ) u_write_merge (
    .state    (state_q),
    .idx      (idx_q),
    .sp_value (sp_q),
    .accept0  (accept0),
    .rd0      (commit0_rd),
    .data0    (commit0_data),
    .accept1  (accept1),
    .rd1      (commit1_rd),
    .data1    (commit1_data),
    .wr_en    (wr_en),
    .wr_data  (wr_data)
  );

  assign register_file = rf_q;
  assign init_done     = init_done_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_regfile_commit_writer.sv
// Directed self-checking bench for regfile_commit_writer.
`ifndef NUMBER_OF_REGISTERS
`define NUMBER_OF_REGISTERS 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module tb_regfile_commit_writer;
  import regfile_commit_writer_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  memory_word_t        sp_init;
  logic                hold;
  logic                c0_valid, c1_valid;
  register_t           c0_rd, c1_rd;
  memory_word_t        c0_data, c1_data;
  logic                c0_ready, c1_ready;
  memory_word_t [31:0] rf;
  logic                init_done;
  logic [31:0]         retired_count;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  regfile_commit_writer #(
    .NUM_REGS (32),
    .SP_REG   (2),
    .COUNT_W  (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sp_init       (sp_init),
    .hold          (hold),
    .commit0_valid (c0_valid),
    .commit0_rd    (c0_rd),
    .commit0_data  (c0_data),
    .commit0_ready (c0_ready),
    .commit1_valid (c1_valid),
    .commit1_rd    (c1_rd),
    .commit1_data  (c1_data),
    .commit1_ready (c1_ready),
    .register_file (rf),
    .init_done     (init_done),
    .retired_count (retired_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_slots();
    c0_valid = 1'b0; c0_rd = '0; c0_data = '0;
    c1_valid = 1'b0; c1_rd = '0; c1_data = '0;
  endtask

  initial begin
    reset   = 1'b0;
    sp_init = 32'h7FFF_FFF0;
    hold    = 1'b0;
    idle_slots();
    repeat (3) step();
    check("reset_init_done", {31'd0, init_done}, 32'd0);
    check("reset_count", retired_count, 32'd0);
    check("reset_ready", {30'd0, c0_ready, c1_ready}, 32'd0);

    // Release; drive a commit during INIT that must be ignored.
    reset    = 1'b1;
    c0_valid = 1'b1; c0_rd = 5'd9; c0_data = 32'hAAAA_AAAA;
    c1_valid = 1'b1; c1_rd = 5'd9; c1_data = 32'hBBBB_BBBB;
    for (int i = 1; i <= 31; i++) begin
      step();
      check("init_ready", {30'd0, c0_ready, c1_ready}, 32'd0);
    end
    check("init_done_at_31", {31'd0, init_done}, 32'd0);
    step();
    check("init_done_at_32", {31'd0, init_done}, 32'd1);
    idle_slots();
    check("init_count", retired_count, 32'd0);
    check("init_sp", rf[2], 32'h7FFF_FFF0);
    for (int r = 0; r < 32; r++) begin
      if (r != 2) check($sformatf("init_zero_r%0d", r), rf[r], 32'd0);
    end
    check("run_ready", {30'd0, c0_ready, c1_ready}, 32'd3);

    // Two different destinations in one cycle.
    c0_valid = 1'b1; c0_rd = 5'd5; c0_data = 32'hDEAD_BEEF;
    c1_valid = 1'b1; c1_rd = 5'd6; c1_data = 32'h0000_1234;
    #2;
    check("no_bypass_r5", rf[5], 32'd0);
    step();
    idle_slots();
    check("dual_r5", rf[5], 32'hDEAD_BEEF);
    check("dual_r6", rf[6], 32'h0000_1234);
    check("dual_count", retired_count, 32'd2);

    // Same destination: younger slot wins.
    c0_valid = 1'b1; c0_rd = 5'd7; c0_data = 32'h1;
    c1_valid = 1'b1; c1_rd = 5'd7; c1_data = 32'h2;
    step();
    idle_slots();
    check("same_rd_r7", rf[7], 32'h2);
    check("same_rd_count", retired_count, 32'd4);

    // Slot 0 alone, then slot 1 alone.
    c0_valid = 1'b1; c0_rd = 5'd7; c0_data = 32'h55;
    step();
    idle_slots();
    check("slot0_r7", rf[7], 32'h55);
    check("slot0_count", retired_count, 32'd5);
    c1_valid = 1'b1; c1_rd = 5'd8; c1_data = 32'h88;
    step();
    idle_slots();
    check("slot1_r8", rf[8], 32'h88);
    check("slot1_r7_kept", rf[7], 32'h55);
    check("slot1_count", retired_count, 32'd6);

    // x0 commit: counted, not written.
    c0_valid = 1'b1; c0_rd = 5'd0; c0_data = 32'hFFFF_FFFF;
    step();
    idle_slots();
    check("x0_r0", rf[0], 32'd0);
    check("x0_count", retired_count, 32'd7);

    // Hold for three cycles with both slots valid.
    hold     = 1'b1;
    c0_valid = 1'b1; c0_rd = 5'd10; c0_data = 32'hA;
    c1_valid = 1'b1; c1_rd = 5'd11; c1_data = 32'hB;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_ready", {30'd0, c0_ready, c1_ready}, 32'd0);
      step();
      check("hold_r10", rf[10], 32'd0);
      check("hold_r11", rf[11], 32'd0);
      check("hold_count", retired_count, 32'd7);
    end
    hold = 1'b0;
    #1;
    check("unhold_ready", {30'd0, c0_ready, c1_ready}, 32'd3);
    step();
    idle_slots();
    check("unhold_r10", rf[10], 32'hA);
    check("unhold_r11", rf[11], 32'hB);
    check("unhold_count", retired_count, 32'd9);

    // Reset mid-RUN with a commit on the reset edge: must be discarded.
    sp_init  = 32'h0000_1000;
    reset    = 1'b0;
    c0_valid = 1'b1; c0_rd = 5'd12; c0_data = 32'hC;
    step();
    idle_slots();
    check("rst_run_r12", rf[12], 32'd0);
    check("rst_run_count", retired_count, 32'd0);
    check("rst_run_done", {31'd0, init_done}, 32'd0);

    // Release, clear idx 0..9, then reset again at idx 10.
    reset = 1'b1;
    repeat (10) step();
    check("mid_init_r5", rf[5], 32'd0);
    check("mid_init_r10", rf[10], 32'hA);
    check("mid_init_r2", rf[2], 32'h0000_1000);
    sp_init = 32'h0000_2000;
    reset   = 1'b0;
    step();
    check("mid_init_rst_done", {31'd0, init_done}, 32'd0);
    reset = 1'b1;
    repeat (31) step();
    check("restart_done_31", {31'd0, init_done}, 32'd0);
    step();
    check("restart_done_32", {31'd0, init_done}, 32'd1);
    check("restart_r10", rf[10], 32'd0);
    check("restart_r11", rf[11], 32'd0);
    check("restart_r2", rf[2], 32'h0000_2000);
    check("restart_count", retired_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
